// File: rtl/ray_if.sv
// Ray stream interface between the camera-ray generator and the DDA stepper.
// Carries one ray per beat over a valid/ready handshake, plus the per-frame
// position snapshot and the end-of-row marker.
interface ray_if;
  logic        ray_valid;
  logic        ray_ready;
  logic [9:0]  ray_x;
  logic [15:0] rayDirX;
  logic [15:0] rayDirY;
  logic [15:0] ray_posX;
  logic [15:0] ray_posY;
  logic        ray_last;

  modport master (
    output ray_valid,
    input  ray_ready,
    output ray_x,
    output rayDirX,
    output rayDirY,
    output ray_posX,
    output ray_posY,
    output ray_last
  );

  modport slave (
    input  ray_valid,
    output ray_ready,
    input  ray_x,
    input  rayDirX,
    input  rayDirY,
    input  ray_posX,
    input  ray_posY,
    input  ray_last
  );
endinterface

// File: rtl/ray_gen.sv
// Per-frame camera-ray generator.
// A frame-start pulse snapshots the player state (Q8.8 signed) and the block
// then streams one ray per screen column: rayDir = dir + plane * cameraX,
// with cameraX = floor(512*x/SCREEN_WIDTH) - 256 built incrementally from a
// quotient/remainder pair so no divider is needed.
// Optional build macro RAY_GEN_SAT_EN: saturate the 17-bit direction sum to
// 16 bits instead of wrapping.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for frame_start; pipeline empty
// RUN      | issuing columns 0..SCREEN_WIDTH-1 on each pipeline advance
// DRAIN    | all columns issued; waiting for the ray_last handshake
module ray_gen #(
  parameter int SCREEN_WIDTH = 320,
  parameter int FRAC_BITS    = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start,
  input  logic [15:0] posX,
  input  logic [15:0] posY,
  input  logic [15:0] dirX,
  input  logic [15:0] dirY,
  input  logic [15:0] planeX,
  input  logic [15:0] planeY,
  ray_if.master       ray,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // per-column step of 512/SCREEN_WIDTH split into whole and fractional parts
  localparam logic [10:0] CAM_QUO = 11'(512 / SCREEN_WIDTH);
  localparam logic [10:0] CAM_REM = 11'(512 % SCREEN_WIDTH);
  localparam logic [10:0] SW_W    = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  LAST_X  = 10'(SCREEN_WIDTH - 1);

  logic [1:0]         state;

  logic signed [15:0] snap_posX;
  logic signed [15:0] snap_posY;
  logic signed [15:0] snap_dirX;
  logic signed [15:0] snap_dirY;
  logic signed [15:0] snap_planeX;
  logic signed [15:0] snap_planeY;

  logic [9:0]         x_cnt;
  logic [10:0]        cam_q;
  logic [10:0]        cam_r;
  logic [10:0]        r_sum;
  logic               r_wrap;
  logic [10:0]        q_next;
  logic [10:0]        r_next;
  logic signed [15:0] cam_now;

  logic               advance;
  logic               issue;

  // issue register: column index and its cameraX
  logic               s0_valid;
  logic [9:0]         s0_x;
  logic signed [15:0] s0_cam;
  logic               s0_last;

  // product stage
  logic               s1_valid;
  logic [9:0]         s1_x;
  logic signed [31:0] s1_prod_x;
  logic signed [31:0] s1_prod_y;
  logic               s1_last;

  // output stage
  logic               out_valid;
  logic [9:0]         out_x;
  logic [15:0]        out_dx;
  logic [15:0]        out_dy;
  logic               out_last;

  logic [16:0]        sum_x;
  logic [16:0]        sum_y;
  logic [15:0]        dx_narrow;
  logic [15:0]        dy_narrow;

  // a full output register only moves when the consumer takes it
  assign advance = !out_valid || ray.ray_ready;
  assign issue   = (state == ST_RUN) && advance;

  // cameraX stepping: remainder can exceed SCREEN_WIDTH at most once per column
  assign r_sum   = cam_r + CAM_REM;
  assign r_wrap  = (r_sum >= SW_W);
  assign r_next  = r_wrap ? (r_sum - SW_W) : r_sum;
  assign q_next  = cam_q + CAM_QUO + {10'd0, r_wrap};
  assign cam_now = 16'({5'd0, cam_q}) - 16'd256;

  // floor shift of the products, then add the direction at 17 bits
  assign sum_x = {snap_dirX[15], snap_dirX} + 17'(s1_prod_x >>> FRAC_BITS);
  assign sum_y = {snap_dirY[15], snap_dirY} + 17'(s1_prod_y >>> FRAC_BITS);

`ifdef RAY_GEN_SAT_EN
  // clamp to the 16-bit range when the top two sum bits disagree
  always_comb begin
    dx_narrow = sum_x[15:0];
    dy_narrow = sum_y[15:0];
    if (sum_x[16] != sum_x[15]) dx_narrow = sum_x[16] ? 16'h8000 : 16'h7FFF;
    if (sum_y[16] != sum_y[15]) dy_narrow = sum_y[16] ? 16'h8000 : 16'h7FFF;
  end
`else
  assign dx_narrow = 16'(sum_x);
  assign dy_narrow = 16'(sum_y);
`endif

  // frame sequencing, snapshot capture and column/cameraX counters
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      x_cnt       <= '0;
      cam_q       <= '0;
      cam_r       <= '0;
      snap_posX   <= '0;
      snap_posY   <= '0;
      snap_dirX   <= '0;
      snap_dirY   <= '0;
      snap_planeX <= '0;
      snap_planeY <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            snap_posX   <= posX;
            snap_posY   <= posY;
            snap_dirX   <= dirX;
            snap_dirY   <= dirY;
            snap_planeX <= planeX;
            snap_planeY <= planeY;
            x_cnt       <= '0;
            cam_q       <= '0;
            cam_r       <= '0;
            busy        <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (advance) begin
            x_cnt <= x_cnt + 10'd1;
            cam_q <= q_next;
            cam_r <= r_next;
            if (x_cnt == LAST_X) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid && ray.ray_ready && out_last) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // three-register ray pipeline sharing one advance enable
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s0_valid  <= 1'b0;
      s0_x      <= '0;
      s0_cam    <= '0;
      s0_last   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_prod_x <= '0;
      s1_prod_y <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_dx    <= '0;
      out_dy    <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s0_valid  <= issue;
      s0_x      <= x_cnt;
      s0_cam    <= cam_now;
      s0_last   <= issue && (x_cnt == LAST_X);

      s1_valid  <= s0_valid;
      s1_x      <= s0_x;
      s1_prod_x <= 32'(snap_planeX) * 32'(s0_cam);
      s1_prod_y <= 32'(snap_planeY) * 32'(s0_cam);
      s1_last   <= s0_last;

      out_valid <= s1_valid;
      out_x     <= s1_x;
      out_dx    <= dx_narrow;
      out_dy    <= dy_narrow;
      out_last  <= s1_last;
    end
  end

  assign ray.ray_valid = out_valid;
  assign ray.ray_x     = out_x;
  assign ray.rayDirX   = out_dx;
  assign ray.rayDirY   = out_dy;
  assign ray.ray_last  = out_last;
  assign ray.ray_posX  = snap_posX;
  assign ray.ray_posY  = snap_posY;

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen: basic frame, backpressure, saturation,
// restart-while-busy, mid-frame reset and mid-frame input changes.
module tb_ray_gen;
  localparam int SW = 320;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in;
  logic        frame_start;
  logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
  logic        busy;
  logic        frame_done;

  ray_if rif ();

  ray_gen #(.SCREEN_WIDTH(SW), .FRAC_BITS(8)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .posX        (posX),
    .posY        (posY),
    .dirX        (dirX),
    .dirY        (dirY),
    .planeX      (planeX),
    .planeY      (planeY),
    .ray         (rif),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] e_posX, e_posY, e_dirX, e_dirY, e_planeX, e_planeY;
  int          hand_n;
  int          hand_x  [3];
  logic [15:0] hand_dx [3];
  logic [15:0] hand_dy [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // direct (non-incremental) reference for one ray direction component
  function automatic logic [15:0] model_dir(input logic [15:0] d, input logic [15:0] p, input int x);
    int cam;
    int prod;
    int sum;
    cam  = (512 * x) / SW - 256;
    prod = $signed(p) * cam;
    sum  = $signed(d) + (prod >>> 8);
`ifdef RAY_GEN_SAT_EN
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
`endif
    return sum[15:0];
  endfunction

  task automatic drive_snapshot_inputs();
    posX = e_posX; posY = e_posY;
    dirX = e_dirX; dirY = e_dirY;
    planeX = e_planeX; planeY = e_planeY;
  endtask

  // mode 0: ready=1; 1: stall at x=10 plus random ready; 2: frame_start again
  // at x=50; 3: inputs change at x=20; 4: reset at x=100
  task automatic run_frame(input int mode);
    int          beats;
    int          done_cnt;
    int          done_cyc;
    int          exp_x;
    int          stall_cnt;
    int          spurious;
    logic        held;
    logic        fs_clear;
    logic [9:0]  h_x;
    logic [15:0] h_dx, h_dy;
    beats = 0; done_cnt = 0; done_cyc = 0; exp_x = 0; stall_cnt = 0;
    spurious = 0; held = 1'b0; fs_clear = 1'b0;
    h_x = '0; h_dx = '0; h_dy = '0;

    drive_snapshot_inputs();
    frame_start   = 1'b1;
    rif.ray_ready = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);

    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk_in);
      if (fs_clear) begin
        frame_start = 1'b0;
        drive_snapshot_inputs();
        fs_clear = 1'b0;
      end
      if (cyc <= 3)
        check($sformatf("valid_edge%0d", cyc), 32'(rif.ray_valid), 32'(cyc == 3));
      if (held) begin
        check("hold_x",  32'(rif.ray_x),   32'(h_x));
        check("hold_dx", 32'(rif.rayDirX), 32'(h_dx));
        check("hold_dy", 32'(rif.rayDirY), 32'(h_dy));
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      if (mode == 4 && rif.ray_valid && rif.ray_x == 10'd100) begin
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        check("rst_valid", 32'(rif.ray_valid),  32'd0);
        check("rst_busy",  32'(busy),           32'd0);
        check("rst_done",  32'(frame_done),     32'd0);
        check("rst_x",     32'(rif.ray_x),      32'd0);
        check("rst_dx",    32'(rif.rayDirX),    32'd0);
        check("rst_dy",    32'(rif.rayDirY),    32'd0);
        check("rst_last",  32'(rif.ray_last),   32'd0);
        check("rst_posx",  32'(rif.ray_posX),   32'd0);
        check("rst_posy",  32'(rif.ray_posY),   32'd0);
        for (int k = 0; k < 20; k++) begin
          @(negedge clk_in);
          if (frame_done || rif.ray_valid || busy) spurious++;
        end
        check("rst_no_activity", 32'(spurious), 32'd0);
        return;
      end

      if (mode == 1) begin
        if (rif.ray_valid && rif.ray_x == 10'd10 && stall_cnt < 5) begin
          rif.ray_ready = 1'b0;
          stall_cnt++;
        end else if (rif.ray_valid && rif.ray_x == 10'd10) begin
          rif.ray_ready = 1'b1;
        end else begin
          rif.ray_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        rif.ray_ready = 1'b1;
      end

      if (rif.ray_valid && rif.ray_ready) begin
        check("beat_x",    32'(rif.ray_x),    32'(exp_x));
        check("beat_dx",   32'(rif.rayDirX),  32'(model_dir(e_dirX, e_planeX, exp_x)));
        check("beat_dy",   32'(rif.rayDirY),  32'(model_dir(e_dirY, e_planeY, exp_x)));
        check("beat_last", 32'(rif.ray_last), 32'(exp_x == SW - 1));
        check("beat_posx", 32'(rif.ray_posX), 32'(e_posX));
        check("beat_posy", 32'(rif.ray_posY), 32'(e_posY));
        for (int h = 0; h < hand_n; h++) begin
          if (hand_x[h] == exp_x) begin
            check($sformatf("hand_dx_x%0d", exp_x), 32'(rif.rayDirX), 32'(hand_dx[h]));
            check($sformatf("hand_dy_x%0d", exp_x), 32'(rif.rayDirY), 32'(hand_dy[h]));
          end
        end
        if (mode == 2 && exp_x == 50) begin
          frame_start = 1'b1;
          posX = 16'h1234; posY = 16'h5678;
          dirX = 16'h0100; dirY = 16'h0100;
          planeX = 16'h0080; planeY = 16'h0080;
          fs_clear = 1'b1;
        end
        if (mode == 3 && exp_x == 20) begin
          posX = 16'h4321;
          dirX = 16'h0100;
        end
        exp_x++;
        beats++;
        held = 1'b0;
      end else if (rif.ray_valid) begin
        held = 1'b1;
        h_x  = rif.ray_x;
        h_dx = rif.rayDirX;
        h_dy = rif.rayDirY;
      end else begin
        held = 1'b0;
      end
    end

    check("beat_count", 32'(beats), 32'(SW));
    check("done_count", 32'(done_cnt), 32'd1);
    if (mode == 1) check("stall_cycles", 32'(stall_cnt), 32'd5);
    else           check("done_edge", 32'(done_cyc), 32'(SW + 3));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      if (frame_done || rif.ray_valid || busy) spurious++;
    end
    check("post_frame_quiet", 32'(spurious), 32'd0);
    drive_snapshot_inputs();
    rif.ray_ready = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0;
    frame_start = 1'b0;
    rif.ray_ready = 1'b1;
    e_posX = '0; e_posY = '0; e_dirX = '0; e_dirY = '0; e_planeX = '0; e_planeY = '0;
    drive_snapshot_inputs();
    hand_n = 0;
    for (int h = 0; h < 3; h++) begin
      hand_x[h] = -1; hand_dx[h] = '0; hand_dy[h] = '0;
    end

    repeat (3) @(negedge clk_in);
    check("reset_valid", 32'(rif.ray_valid), 32'd0);
    check("reset_busy",  32'(busy),          32'd0);
    check("reset_done",  32'(frame_done),    32'd0);
    check("reset_x",     32'(rif.ray_x),     32'd0);
    check("reset_dx",    32'(rif.rayDirX),   32'd0);
    check("reset_last",  32'(rif.ray_last),  32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // basic frame with hand-computed columns
    e_posX = 16'h0180; e_posY = 16'h0280;
    e_dirX = 16'hFF00; e_dirY = 16'h0000;
    e_planeX = 16'h0000; e_planeY = 16'h00A9;
    hand_n = 3;
    hand_x[0] = 0;   hand_dx[0] = 16'hFF00; hand_dy[0] = 16'hFF57;
    hand_x[1] = 160; hand_dx[1] = 16'hFF00; hand_dy[1] = 16'h0000;
    hand_x[2] = 319; hand_dx[2] = 16'hFF00; hand_dy[2] = 16'h00A7;
    run_frame(0);

    // backpressure
    hand_n = 0;
    e_posX = 16'h0A40; e_posY = 16'hF3C0;
    run_frame(1);

    // saturation corner
    e_posX = 16'h0100; e_posY = 16'h0100;
    e_dirX = 16'h7F00; e_dirY = 16'h0000;
    e_planeX = 16'h0200; e_planeY = 16'h0000;
    hand_n = 2;
    hand_x[0] = 0; hand_dx[0] = 16'h7D00; hand_dy[0] = 16'h0000;
`ifdef RAY_GEN_SAT_EN
    hand_x[1] = 319; hand_dx[1] = 16'h7FFF; hand_dy[1] = 16'h0000;
`else
    hand_x[1] = 319; hand_dx[1] = 16'h80FC; hand_dy[1] = 16'h0000;
`endif
    run_frame(0);

    // frame_start while busy is ignored
    hand_n = 0;
    e_posX = 16'h0500; e_posY = 16'h0600;
    e_dirX = 16'h00B5; e_dirY = 16'hFF4B;
    e_planeX = 16'h0070; e_planeY = 16'h0070;
    run_frame(2);

    // inputs changing mid-frame do not reach the stream
    e_posX = 16'h0233; e_posY = 16'h0744;
    e_dirX = 16'hFF00; e_dirY = 16'h0000;
    e_planeX = 16'h0000; e_planeY = 16'h00A9;
    run_frame(3);

    // mid-frame reset, then a clean frame
    run_frame(4);
    e_posX = 16'h0300; e_posY = 16'h0400;
    e_dirX = 16'h0000; e_dirY = 16'h0100;
    e_planeX = 16'hFF57; e_planeY = 16'h0000;
    run_frame(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ray_gen.md
Name: ray_gen

Overview:
- Per-frame camera-ray generator sitting directly downstream of the button/movement control stage.
- On a frame-start pulse it snapshots the player state (pos/dir/plane, signed Q8.8).
- It then streams one ray per screen column to the DDA stepper over a valid/ready handshake.
- Ray direction: rayDir = dir + plane*cameraX, where cameraX spans -1.0 to just under +1.0 across the screen.

Parameters:
- SCREEN_WIDTH, 320, number of columns per frame (2..1023).
- FRAC_BITS, 8, fractional bits of all Q-format values; fixed at 8, used only for shift amounts.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous reset, active-low.
- frame_start  in  1  one-cycle pulse requesting a new frame.
- posX, posY  in  16  player position, Q8.8 signed.
- dirX, dirY  in  16  direction vector, Q8.8 signed.
- planeX, planeY  in  16  camera plane, Q8.8 signed.
- ray_valid  out  1  ray beat valid.
- ray_ready  in  1  downstream accepts the beat.
- ray_x  out  10  column index.
- rayDirX, rayDirY  out  16  ray direction, Q8.8 signed.
- ray_posX, ray_posY  out  16  snapshotted position, constant for the frame.
- ray_last  out  1  set on the column SCREEN_WIDTH-1 beat.
- busy  out  1  high from snapshot until frame_done.
- frame_done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - State goes to IDLE; all outputs are 0.
  - The pipeline is flushed. Reset mid-frame abandons the frame; no frame_done is issued.
- State machine IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: frame_start=1 snapshots all six inputs, clears the column counter and cameraX accumulator, sets busy, and enters RUN.
  - RUN: issues column x into stage 1 each cycle the pipeline advances. Enter DRAIN after issuing x=SCREEN_WIDTH-1.
  - DRAIN: waits for the ray_last handshake. The next cycle pulses frame_done, drops busy, and returns to IDLE.
- frame_start in RUN or DRAIN is ignored, with no effect on the current frame.
- cameraX is exact, with no divider: cameraX(x) = floor(512*x/SCREEN_WIDTH) - 256, in Q8.8.
  - Computed incrementally with quotient/remainder registers.
  - Per column: q += 512/SW and r += 512%SW (elaboration-time constants). If r >= SW then r -= SW and q += 1.
  - cameraX = q - 256.
- Pipeline (2 stages):
  - Stage 1 registers the 32-bit signed products planeX*cameraX and planeY*cameraX, plus x.
  - Stage 2 arithmetic-shifts each product right by 8 (floor) and adds dirX/dirY to form rayDirX/rayDirY. The sum is 17-bit, narrowed to 16 per the optional feature.
  - Stage 2 is the output register.
- Handshake:
  - A transfer occurs when ray_valid & ray_ready.
  - Global advance enable = !ray_valid | ray_ready.
  - While stalled, all outputs hold stable and no column is skipped or duplicated.
  - ray_valid never drops without a transfer, except on reset.
- Latency:
  - With ray_ready held 1, ray_valid rises at the 3rd edge after the edge sampling frame_start.
  - Thereafter one ray per cycle; SCREEN_WIDTH beats in total.
  - frame_done is asserted SCREEN_WIDTH+3 edges after the snapshot.
- ray_posX/ray_posY come from the snapshot registers. Input changes mid-frame have no effect.

Optional Feature:
- Macro: RAY_GEN_SAT_EN.
- Defined: the 17-bit stage-2 sum saturates to 0x7FFF / 0x8000 on overflow.
- Undefined: the sum wraps (two's-complement truncation to 16 bits).
- Products never overflow 32 bits in either case.

Test Plan:
- Basic frame: SW=320, dir=(0xFF00,0x0000), plane=(0x0000,0x00A9), ready=1, frame_start pulse.
  - x=0 -> (0xFF00, 0xFF57).
  - x=160 -> (0xFF00, 0x0000).
  - x=319 -> (0xFF00, 0x00A7) with ray_last=1.
  - Exactly 320 beats, then a frame_done pulse; first valid 3 edges after frame_start.
- Backpressure: deassert ray_ready for 5 cycles while ray_x=10, and also toggle ready randomly.
  - Outputs hold during stall; x sequence is 0..319 contiguous.
  - Each column's rayDir matches the reference model.
- Saturation: dir=(0x7F00,0), plane=(0x0200,0), x=319 (cameraX=254).
  - With RAY_GEN_SAT_EN, rayDirX=0x7FFF.
  - Without it, rayDirX=0x80FC.
- Busy-start ignore: pulse frame_start again at ray_x=50 with different inputs.
  - Frame continues unchanged; one frame_done; ray_posX/Y stay at the first snapshot.
- Mid-frame reset: rst_in=0 for 1 cycle at ray_x=100.
  - All outputs 0 next cycle, no frame_done.
  - A following frame_start produces a clean frame from x=0.
- Input change mid-frame: change posX/dirX at x=20.
  - Outputs for columns 20..319 still use the snapshot values.
